// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter: FSM state, requester
// index type, default idle word and the counter-width helper.
package disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam int NREQ_MAX = 4;

  localparam logic [15:0] IDLE_VALUE_DEFAULT = 16'h0000;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((longint'(1) << w) < longint'(value)) w++;
    return (w < 1) ? 1 : w;
  endfunction

  localparam int IDX_W = clog2(NREQ_MAX);
  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/disp_dwell_timer.sv
// Loadable saturating down-counter that sets how long each grant holds the
// display. A load takes priority over counting.
module disp_dwell_timer
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic cnt_zero
);

  localparam int            CW     = clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of all others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin arbiter granting one requester at a time ownership of a
// four-digit seven-segment display for at least DWELL_CYCLES clocks.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int          NREQ         = 3,
  parameter int          DWELL_CYCLES = 100_000_000,
  parameter logic [15:0] IDLE_VALUE   = IDLE_VALUE_DEFAULT
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data,
  output logic [NREQ-1:0]      grant,
  output logic [15:0]          disp_bits,
  output logic                 disp_valid
);

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  idx_t            owner_q, owner_d;
  idx_t            rr_ptr_q, rr_ptr_d;
  logic [15:0]     disp_bits_q, disp_bits_d;

  idx_t  win_idx;
  idx_t  cand;
  logic  picked;
  logic  any_req;
  logic  take;
  logic  cnt_zero;
  logic  load;
  logic  timer_en;

  assign any_req  = |req;
  assign timer_en = (state_q == SHOW);

  // Winner is the first requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    picked  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = idx_t'((int'(rr_ptr_q) + k) % NREQ);
      if (!picked && req[cand]) begin
        picked  = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SHOW;
          take    = 1'b1;
        end
      end
      SHOW: begin
        if (cnt_zero) begin
          state_d = any_req ? SHOW : IDLE;
          take    = any_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    disp_bits_d = disp_bits_q;
    load        = 1'b0;
    if (take) begin
      owner_d     = win_idx;
      grant_d     = NREQ'(1) << win_idx;
      rr_ptr_d    = idx_t'((int'(win_idx) + 1) % NREQ);
      disp_bits_d = data[{win_idx, 4'b0000} +: 16];
      load        = 1'b1;
    end else if ((state_q == SHOW) && cnt_zero) begin
      grant_d     = '0;
      disp_bits_d = IDLE_VALUE;
    end else if ((state_q == SHOW) && req[owner_q]) begin
      disp_bits_d = data[{owner_q, 4'b0000} +: 16];
    end
  end

  // State register
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      disp_bits_q <= IDLE_VALUE;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      disp_bits_q <= disp_bits_d;
    end
  end

  disp_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .clk      (CLK100MHZ),
    .rst_n    (reset_n),
    .load     (load),
    .en       (timer_en),
    .cnt_zero (cnt_zero)
  );

  assign grant      = grant_q;
  assign disp_bits  = disp_bits_q;
  assign disp_valid = |grant_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter with NREQ=3, DWELL_CYCLES=4: stimulus
// queues cycle-stamped expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_disp_arbiter;

  localparam int NREQ  = 3;
  localparam int DWELL = 4;

  logic              CLK100MHZ;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] data;
  logic [NREQ-1:0]   grant;
  logic [15:0]       disp_bits;
  logic              disp_valid;

  typedef struct {
    int          cyc;
    string       name;
    logic [2:0]  g;
    logic [15:0] b;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   base;

  disp_arbiter #(
    .NREQ         (NREQ),
    .DWELL_CYCLES (DWELL),
    .IDLE_VALUE   (16'h0000)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .reset_n    (reset_n),
    .req        (req),
    .data       (data),
    .grant      (grant),
    .disp_bits  (disp_bits),
    .disp_valid (disp_valid)
  );

  initial begin
    CLK100MHZ = 1'b0;
    forever #5 CLK100MHZ = ~CLK100MHZ;
  end

  always @(posedge CLK100MHZ) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int dly, input string name, input logic [2:0] g,
                          input logic [15:0] b);
    exp_t e;
    e.cyc  = cyc + dly;
    e.name = $sformatf("%s@%0d", name, dly);
    e.g    = g;
    e.b    = b;
    sb_q.push_back(e);
  endtask

  task automatic push_run(input int first, input int last, input string name,
                          input logic [2:0] g, input logic [15:0] b);
    for (int d = first; d <= last; d++) push_exp(d, name, g, b);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  // Monitor: compares {grant, disp_valid, disp_bits} for each due entry.
  always @(negedge CLK100MHZ) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: entry for cycle %0d missed, now cycle %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        check(mon_e.name, {12'h000, grant, disp_valid, disp_bits},
              {12'h000, mon_e.g, |mon_e.g, mon_e.b});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    req     = 3'b111;
    data    = {16'h3333, 16'h2222, 16'h1111};

    // Held reset with every requester high
    wait_cycles(3);
    check("rst_grant", {29'b0, grant}, 32'h0);
    check("rst_valid", {31'b0, disp_valid}, 32'h0);
    check("rst_bits",  {16'h0, disp_bits}, 32'h0);

    // Release, then full rotation with req=111: each grant lasts 4 cycles
    reset_n = 1'b1;
    push_run(1, 4,   "rot0", 3'b001, 16'h1111);
    push_run(5, 8,   "rot1", 3'b010, 16'h2222);
    push_run(9, 12,  "rot2", 3'b100, 16'h3333);
    push_exp(13,     "rot0b", 3'b001, 16'h1111);
    wait_cycles(13);

    // Owner drops mid-dwell: word held, then idle at expiry
    req = 3'b000;
    push_run(1, 3, "drop0", 3'b001, 16'h1111);
    push_exp(4,    "idle0", 3'b000, 16'h0000);
    wait_cycles(4);

    // Single owner 1 with tracking data and a lost req[0] pulse
    req           = 3'b010;
    data[31:16]   = 16'h1234;
    push_exp(1, "own1", 3'b010, 16'h1234);
    wait_cycles(1);
    data[31:16]   = 16'h5678;
    push_run(1, 11, "own1trk", 3'b010, 16'h5678);
    wait_cycles(5);
    req = 3'b011;
    wait_cycles(1);
    req = 3'b010;
    wait_cycles(3);
    req           = 3'b000;
    data[31:16]   = 16'h9999;
    push_exp(3, "idle1", 3'b000, 16'h0000);
    wait_cycles(3);

    // Early drop of requester 2
    req           = 3'b100;
    data[47:32]   = 16'hABCD;
    push_exp(1, "own2", 3'b100, 16'hABCD);
    wait_cycles(1);
    req           = 3'b000;
    data[47:32]   = 16'hEEEE;
    push_run(1, 3, "own2hold", 3'b100, 16'hABCD);
    push_exp(4,    "idle2", 3'b000, 16'h0000);
    wait_cycles(4);

    // Tie from IDLE with rr_ptr=0: req=110 -> requester 1
    req = 3'b110;
    push_exp(1, "tie_p0", 3'b010, 16'h9999);
    wait_cycles(1);
    req = 3'b000;
    push_run(1, 3, "tie_p0hold", 3'b010, 16'h9999);
    push_exp(4,    "idle3", 3'b000, 16'h0000);
    wait_cycles(4);

    // Tie with rr_ptr=2: req=011 wraps to requester 0
    req = 3'b011;
    push_exp(1, "tie_wrap", 3'b001, 16'h1111);
    wait_cycles(2);

    // Mid-dwell asynchronous reset pulse of 3 ns at grant cycle 2
    #1 reset_n = 1'b0;
    #1;
    check("mrst_grant", {29'b0, grant}, 32'h0);
    check("mrst_valid", {31'b0, disp_valid}, 32'h0);
    check("mrst_bits",  {16'h0, disp_bits}, 32'h0);
    #2 reset_n = 1'b1;
    // rr_ptr back at 0, so req=011 goes to requester 0 rather than 1
    push_exp(1, "mrst_regrant", 3'b001, 16'h1111);
    wait_cycles(1);
    req = 3'b000;
    push_run(1, 3, "mrst_hold", 3'b001, 16'h1111);
    push_exp(4,    "idle4", 3'b000, 16'h0000);
    wait_cycles(4);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) wait_cycles(1);
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never compared", mon_e.name, mon_e.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
